tx_gearbox_ctrl: RTL and testbench

TX_GEARBOX_CTRL -- requirements
Module: tx_gearbox_ctrl

---
 rtl/pcs_pkg.sv | 27 ++
 rtl/gb_seq_counter.sv | 25 ++
 rtl/tx_gearbox_ctrl.sv | 126 ++++++++++++
 tb/tb_tx_gearbox_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS constants, block type and controller state encoding for the TX gearbox path.
package pcs_pkg;

   // Last gearbox sequence value; the gearbox pauses for one cycle at this slot.
   localparam logic [5:0]  GB_SEQ_MAX  = 6'd32;

   // Idle control block inserted when no payload block is available (bit 0 first on the line).
   localparam logic [1:0]  IDLE_HEADER = 2'b01;
   localparam logic [63:0] IDLE_BLOCK  = 64'h0000_0000_0000_001E;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } gb_state_e;

   // One 66-bit PCS block: sync header plus 64-bit payload.
   typedef struct packed {
      logic [1:0]  header;
      logic [63:0] data;
   } pcs_block_t;

   // Sequence successor over 0..32 with wrap back to 0.
   function automatic logic [5:0] next_seq(input logic [5:0] seq);
      return (seq == GB_SEQ_MAX) ? 6'd0 : seq + 6'd1;
   endfunction

endpackage

// File: rtl/gb_seq_counter.sv
// Gearbox sequence counter: walks 0..32 and wraps, or parks at 32 while the controller is idle.
module gb_seq_counter
   import pcs_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load_max,
   input  logic       advance,
   output logic [5:0] seq,
   output logic [5:0] nseq
);

   assign nseq = next_seq(seq);

   // Sequence register: reset and load_max park at 32, advance steps to the successor.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (reset || load_max) begin
         seq <= GB_SEQ_MAX;
      end else if (advance) begin
         seq <= nseq;
      end
   end

endmodule

// File: rtl/tx_gearbox_ctrl.sv
// TX gearbox controller: splits 66-bit PCS blocks into 32-bit gearbox words, inserting idle
// blocks on underflow and only stopping at block boundaries.
module tx_gearbox_ctrl
   import pcs_pkg::*;
#(
   parameter int UNDERFLOW_CNT_WIDTH = 16
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_enable,
   input  logic [63:0]                    s_data,
   input  logic [1:0]                     s_header,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic [31:0]                    o_gb_data,
   output logic [1:0]                     o_gb_header,
   output logic [5:0]                     o_gb_seq,
   output logic                           o_gb_pause,
   output logic                           o_running,
   output logic [UNDERFLOW_CNT_WIDTH-1:0] o_underflow_count
);

   gb_state_e   state;
   gb_state_e   state_next;
   logic [5:0]  nseq;
   logic        step;        // RUN edge that advances the sequence (not the exit edge)
   logic        park;
   logic        load_slot;   // a fresh block goes onto the line at this edge
   logic        consume;
   logic        underflow;
   logic        accept;
   logic        hold_valid;
   pcs_block_t  hold;
   pcs_block_t  slot_block;
   logic [31:0] upper_word;

   gb_seq_counter u_seq_counter (
      .clk      (i_clk),
      .reset    (i_reset),
      .load_max (park),
      .advance  (step),
      .seq      (o_gb_seq),
      .nseq     (nseq)
   );

   // Next state and per-edge slot decisions.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
      state_next = state;
      step       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (i_enable) state_next = ST_RUN;
         end
         ST_RUN: begin
            // Leave only at a block boundary so a block is never split across a stop.
            if (!i_enable && !nseq[0]) begin
               state_next = ST_IDLE;
            end else begin
               step = 1'b1;
            end
         end
      endcase
      park      = !step;
      // The exit edge emits nothing, so the held block is only taken when it really goes out.
      load_slot = step && !nseq[0] && (nseq != GB_SEQ_MAX);
      consume   = load_slot && hold_valid;
      underflow = load_slot && !hold_valid;
      s_ready   = !hold_valid || consume;
      accept    = s_valid && s_ready;
      slot_block = hold_valid ? hold : pcs_block_t'{header: IDLE_HEADER, data: IDLE_BLOCK};
   end

   // Controller state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Single-entry hold register; refilled on the same edge it drains when both happen.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hold_valid <= 1'b0;
         hold       <= '0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold       <= pcs_block_t'{header: s_header, data: s_data};
      end else if (consume) begin
         hold_valid <= 1'b0;
      end
   end

   // Gearbox word, header and pause: lower word on even slots, upper word on odd slots.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_gb_data   <= '0;
         o_gb_header <= '0;
         o_gb_pause  <= 1'b1;
         upper_word  <= '0;
      end else begin
         o_gb_pause <= !step || (nseq == GB_SEQ_MAX);
         if (load_slot) begin
            o_gb_data   <= slot_block.data[31:0];
            o_gb_header <= slot_block.header;
            upper_word  <= slot_block.data[63:32];
         end else if (step && nseq[0]) begin
            o_gb_data <= upper_word;
         end
      end
   end

   // Saturating count of idle blocks inserted on underflow.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_underflow_count <= '0;
      end else if (underflow && (o_underflow_count != '1)) begin
         o_underflow_count <= o_underflow_count + UNDERFLOW_CNT_WIDTH'(1);
      end
   end

   assign o_running = (state == ST_RUN);

endmodule

// File: tb/tb_tx_gearbox_ctrl.sv
// Bench for tx_gearbox_ctrl: a frame-level model (33-slot frame, queue of pending blocks,
// block currently on the line) is compared against the DUT every cycle, plus literal pins.
module tb_tx_gearbox_ctrl;

   localparam int          CW       = 8;   // narrow counter keeps the saturation run short
   localparam longint      CW_MAX   = (longint'(1) << CW) - 1;
   localparam logic [65:0] IDLE_BLK = {2'b01, 64'h0000_0000_0000_001E};

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_enable;
   logic [63:0]   s_data;
   logic [1:0]    s_header;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   o_gb_data;
   logic [1:0]    o_gb_header;
   logic [5:0]    o_gb_seq;
   logic          o_gb_pause;
   logic          o_running;
   logic [CW-1:0] o_underflow_count;

   tx_gearbox_ctrl #(.UNDERFLOW_CNT_WIDTH(CW)) dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_enable          (i_enable),
      .s_data            (s_data),
      .s_header          (s_header),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .o_gb_data         (o_gb_data),
      .o_gb_header       (o_gb_header),
      .o_gb_seq          (o_gb_seq),
      .o_gb_pause        (o_gb_pause),
      .o_running         (o_running),
      .o_underflow_count (o_underflow_count)
   );

   always #5 i_clk = ~i_clk;

   int          n_cmp    = 0;
   int          n_fail   = 0;
   bit          check_en = 1'b0;
   bit          rnd_mode = 1'b0;
   bit          seen;
   int          blk_k    = 0;
   logic [63:0] blk_data;
   logic [1:0]  blk_hdr;

   // Model state: pending blocks, block on the line, slot position in the frame.
   logic [65:0] m_pend[$];
   logic [65:0] m_cur   = '0;
   int          m_pos   = 32;
   bit          m_run   = 1'b0;
   longint      m_under = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_pos();
      return (m_pos == 32) ? 0 : m_pos + 1;
   endfunction

   // A block is accepted when nothing is pending or the pending one leaves on this edge.
   function automatic bit exp_ready();
      int n = next_pos();
      return (m_pend.size() == 0) ||
             (m_run && (i_enable === 1'b1) && (n % 2 == 0) && (n < 32));
   endfunction

   // Frame-level reference: advance one slot per enabled cycle, stop only at block boundaries.
   always @(posedge i_clk) begin : model
      bit acc;
      int n;
      acc = (s_valid === 1'b1) && exp_ready();
      n   = next_pos();
      if (i_reset === 1'b1) begin
         m_run   = 1'b0;
         m_pos   = 32;
         m_cur   = '0;
         m_under = 0;
         m_pend.delete();
      end else begin
         if (!m_run) begin
            if (i_enable === 1'b1) m_run = 1'b1;
         end else if ((i_enable !== 1'b1) && (n % 2 == 0)) begin
            m_run = 1'b0;
            m_pos = 32;
         end else begin
            m_pos = n;
            if ((n % 2 == 0) && (n < 32)) begin
               if (m_pend.size() > 0) begin
                  m_cur = m_pend.pop_front();
               end else begin
                  m_cur = IDLE_BLK;
                  m_under++;
               end
            end
         end
         if (acc) m_pend.push_back({s_header, s_data});
      end
   end

   // Per-cycle comparison of every DUT output against the model, mid low phase.
   always @(negedge i_clk) begin
      #2;
      if (check_en) begin
         check("s_ready", 64'(s_ready), 64'(exp_ready()));
         check("gb_seq", 64'(o_gb_seq), 64'(m_pos));
         check("gb_pause", 64'(o_gb_pause), 64'(m_pos == 32));
         check("gb_data", 64'(o_gb_data),
               64'(((m_pos < 32) && (m_pos % 2 == 0)) ? m_cur[31:0] : m_cur[63:32]));
         check("gb_header", 64'(o_gb_header), 64'(m_cur[65:64]));
         check("running", 64'(o_running), 64'(m_run));
         check("underflow_count", 64'(o_underflow_count),
               64'((m_under > CW_MAX) ? CW_MAX : m_under));
      end
   end

   task automatic new_block();
      if (rnd_mode) begin
         blk_data = {$urandom, $urandom};
         blk_hdr  = 2'($urandom_range(1, 2));
      end else begin
         blk_data = {32'hB000_0000 | 32'(blk_k), 32'hA000_0000 | 32'(blk_k)};
         blk_hdr  = 2'b10;
      end
      blk_k++;
   endtask

   task automatic wait_neg();
      @(negedge i_clk);
   endtask

   // Drive inputs for the coming edge; move to a new block once the current one is taken.
   task automatic drive(input logic rst, input logic en, input logic v);
      i_reset  = rst;
      i_enable = en;
      s_valid  = v;
      s_data   = blk_data;
      s_header = blk_hdr;
      #4;
      if (v && (s_ready === 1'b1) && !rst) new_block();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      i_reset  = 1'b1;
      i_enable = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      s_header = '0;
      new_block();
      for (int i = 0; i < 3; i++) begin
         wait_neg();
         drive(1'b1, 1'b0, 1'b0);
      end
      check_en = 1'b1;

      // Continuous stream from reset, enable high throughout.
      for (int c = 0; c < 330; c++) begin
         wait_neg();
         case (c)
            0: begin
               check("rst_seq", 64'(o_gb_seq), 64'd32);
               check("rst_pause", 64'(o_gb_pause), 64'd1);
               check("rst_data", 64'(o_gb_data), 64'd0);
               check("rst_header", 64'(o_gb_header), 64'd0);
               check("rst_running", 64'(o_running), 64'd0);
               check("rst_count", 64'(o_underflow_count), 64'd0);
               check("rst_ready", 64'(s_ready), 64'd1);
            end
            1: begin
               check("enter_running", 64'(o_running), 64'd1);
               check("enter_seq", 64'(o_gb_seq), 64'd32);
            end
            2: begin
               check("first_seq", 64'(o_gb_seq), 64'd0);
               check("b0_lo", 64'(o_gb_data), 64'hA000_0000);
               check("b0_hdr", 64'(o_gb_header), 64'h2);
            end
            3: check("b0_hi", 64'(o_gb_data), 64'hB000_0000);
            4: check("b1_lo", 64'(o_gb_data), 64'hA000_0001);
            34: begin
               check("frame_end_seq", 64'(o_gb_seq), 64'd32);
               check("frame_end_pause", 64'(o_gb_pause), 64'd1);
            end
            35: check("b16_lo", 64'(o_gb_data), 64'hA000_0010);
            default: ;
         endcase
         drive(1'b0, 1'b1, 1'b1);
      end
      wait_neg();
      check("stream_no_underflow", 64'(o_underflow_count), 64'd0);
      drive(1'b0, 1'b1, 1'b1);

      // Starve the source until exactly one idle block goes out, then resume.
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         wait_neg();
         if ((o_gb_header == 2'b01) && (o_gb_data == 32'h0000_001E)) seen = 1'b1;
         drive(1'b0, 1'b1, seen);
      end
      check("idle_lo_seen", 64'(seen), 64'd1);
      wait_neg();
      check("idle_hi_data", 64'(o_gb_data), 64'd0);
      check("idle_hi_header", 64'(o_gb_header), 64'h1);
      check("underflow_once", 64'(o_underflow_count), 64'd1);
      drive(1'b0, 1'b1, 1'b1);

      // Drop enable on a lower word: the upper word still goes out, then the controller idles.
      seen = 1'b0;
      for (int c = 0; c < 80 && !seen; c++) begin
         wait_neg();
         if (o_gb_seq == 6'd4) seen = 1'b1;
         drive(1'b0, !seen, 1'b1);
      end
      check("seq4_reached", 64'(seen), 64'd1);
      wait_neg();
      check("drop_hi_seq", 64'(o_gb_seq), 64'd5);
      check("drop_hi_running", 64'(o_running), 64'd1);
      drive(1'b0, 1'b0, 1'b1);
      wait_neg();
      check("drop_idle_seq", 64'(o_gb_seq), 64'd32);
      check("drop_idle_pause", 64'(o_gb_pause), 64'd1);
      check("drop_idle_running", 64'(o_running), 64'd0);
      drive(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         wait_neg();
         drive(1'b0, 1'b0, 1'b1);
      end
      for (int c = 0; c < 10; c++) begin
         wait_neg();
         drive(1'b0, 1'b1, 1'b1);
      end

      // Reset mid-block at seq 17, with a block offered in the reset cycle.
      seen = 1'b0;
      for (int c = 0; c < 80 && !seen; c++) begin
         wait_neg();
         if (o_gb_seq == 6'd17) seen = 1'b1;
         drive(seen, 1'b1, 1'b1);
      end
      check("seq17_reached", 64'(seen), 64'd1);
      wait_neg();
      check("midrst_seq", 64'(o_gb_seq), 64'd32);
      check("midrst_pause", 64'(o_gb_pause), 64'd1);
      check("midrst_data", 64'(o_gb_data), 64'd0);
      check("midrst_ready", 64'(s_ready), 64'd1);
      drive(1'b0, 1'b1, 1'b1);

      // Random backpressure and occasional enable drops with random payloads.
      rnd_mode = 1'b1;
      new_block();
      for (int c = 0; c < 1500; c++) begin
         wait_neg();
         drive(1'b0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0);
      end

      // Starve a freshly reset controller long enough to saturate the underflow counter.
      for (int c = 0; c < 2; c++) begin
         wait_neg();
         drive(1'b1, 1'b0, 1'b0);
      end
      for (int c = 0; c < 600; c++) begin
         wait_neg();
         drive(1'b0, 1'b1, 1'b0);
      end
      wait_neg();
      check("count_saturated", 64'(o_underflow_count), 64'(CW_MAX));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
